// File: rtl/ysyx_24110015_idu.sv
// Instruction decode stage: combinational RV32I/E decode of the fetched word,
// captured with pc/inst into a one-entry valid/ready pipeline register.
module ysyx_24110015_idu #(
    parameter bit RVE = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [31:0] out_imm,
    output logic [2:0]  out_fmt,
    output logic        out_rd_we,
    output logic        out_illegal
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;
    localparam int unsigned FMTW = 3;

    localparam logic [FMTW-1:0] FMT_R = FMTW'(0);
    localparam logic [FMTW-1:0] FMT_I = FMTW'(1);
    localparam logic [FMTW-1:0] FMT_S = FMTW'(2);
    localparam logic [FMTW-1:0] FMT_B = FMTW'(3);
    localparam logic [FMTW-1:0] FMT_U = FMTW'(4);
    localparam logic [FMTW-1:0] FMT_J = FMTW'(5);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [XLEN-1:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [XLEN-1:0] INST_EBREAK = 32'h0010_0073;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [REGW-1:0] rs1, rs2, rd;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [XLEN-1:0] dec_imm;
    logic [FMTW-1:0] dec_fmt;
    logic            enc_bad, rve_bad, no_wb;
    logic            use_rs1, use_rs2, use_rd;
    logic            dec_illegal, dec_rd_we;
    logic            accept, transfer;

    assign opcode = in_inst[6:0];
    assign rd     = in_inst[11:7];
    assign f3     = in_inst[14:12];
    assign rs1    = in_inst[19:15];
    assign rs2    = in_inst[24:20];
    assign f7     = in_inst[31:25];

    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{20{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{12{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    // Opcode map: format, immediate, encoding legality and which register fields are live.
    always_comb begin
        dec_fmt = FMT_I;
        dec_imm = '0;
        enc_bad = 1'b0;
        no_wb   = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                dec_fmt = FMT_U;
                dec_imm = imm_u;
                use_rd  = 1'b1;
            end
            OPC_JAL: begin
                dec_fmt = FMT_J;
                dec_imm = imm_j;
                use_rd  = 1'b1;
            end
            OPC_JALR: begin
                dec_imm = imm_i;
                enc_bad = (f3 != 3'b000);
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            OPC_BRANCH: begin
                dec_fmt = FMT_B;
                dec_imm = imm_b;
                enc_bad = (f3 == 3'b010) || (f3 == 3'b011);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                dec_imm = imm_i;
                enc_bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            OPC_STORE: begin
                dec_fmt = FMT_S;
                dec_imm = imm_s;
                enc_bad = (f3 > 3'b010);
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_OPIMM: begin
                dec_imm = imm_i;
                if (f3 == 3'b001) begin
                    enc_bad = (f7 != 7'b0000000);
                end else if (f3 == 3'b101) begin
                    enc_bad = (f7 != 7'b0000000) && (f7 != 7'b0100000);
                end
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            OPC_OP: begin
                dec_fmt = FMT_R;
                enc_bad = !((f7 == 7'b0000000) ||
                            ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
            end
            OPC_SYSTEM: begin
                dec_imm = imm_i;
                if ((in_inst == INST_ECALL) || (in_inst == INST_EBREAK)) begin
                    no_wb = 1'b1;
                end else begin
                    enc_bad = (f3 == 3'b000) || (f3 == 3'b100);
                end
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            default: begin
                enc_bad = 1'b1;
            end
        endcase
    end

    // RV32E has only x0..x15: any live register field reaching x16+ is illegal.
    assign rve_bad = RVE && ((use_rs1 && rs1[4]) || (use_rs2 && rs2[4]) || (use_rd && rd[4]));

    assign dec_illegal = enc_bad || rve_bad;
    assign dec_rd_we   = !dec_illegal && !no_wb && (dec_fmt != FMT_B) &&
                         (dec_fmt != FMT_S) && (rd != REGW'(0));

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;

    // Pipeline register; flush only drops the valid bit, payload may stay stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_pc      <= '0;
            out_inst    <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_rd      <= '0;
            out_imm     <= '0;
            out_fmt     <= '0;
            out_rd_we   <= 1'b0;
            out_illegal <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_pc      <= in_pc;
            out_inst    <= in_inst;
            out_rs1     <= rs1;
            out_rs2     <= rs2;
            out_rd      <= rd;
            out_imm     <= dec_imm;
            out_fmt     <= dec_fmt;
            out_rd_we   <= dec_rd_we;
            out_illegal <= dec_illegal;
        end else if (transfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/ysyx_24110015_idu.md
# ysyx_24110015_idu

Instruction decode unit for the NPC core. Sits directly downstream of the instruction fetch unit and upstream of the execute unit. Takes a fetched `{pc, inst}` pair through a valid/ready handshake, decodes it into register indices, a sign-extended immediate, a format code and an illegal flag, and holds the result in a one-entry pipeline register with its own valid/ready handshake toward the execute unit.

## Interface
- `RVE`, default 0: when 1, any used register index with bit 4 set is illegal (RV32E).
- `clk` input 1: clock. All state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: fetch stage presents a valid `in_pc`/`in_inst`.
- `in_ready` output 1: decode can accept this cycle.
- `in_pc` input 32: PC of the presented instruction.
- `in_inst` input 32: instruction word.
- `flush` input 1: squash the held entry and any input this cycle (branch/trap redirect).
- `out_valid` output 1: decoded entry valid.
- `out_ready` input 1: execute stage accepts the entry.
- `out_pc` output 32: PC of the held entry.
- `out_inst` output 32: raw instruction of the held entry.
- `out_rs1`, `out_rs2`, `out_rd` output 5: `inst[19:15]`, `inst[24:20]`, `inst[11:7]`.
- `out_imm` output 32: decoded immediate.
- `out_fmt` output 3: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J.
- `out_rd_we` output 1: instruction writes `rd`, and `rd`≠0.
- `out_illegal` output 1: encoding not in the supported RV32I/E subset.

## Operation
- Accept when `in_valid && in_ready`. Transfer when `out_valid && out_ready`.
- `in_ready = !flush && (!out_valid || out_ready)`. Combinational; no skid buffer.
- Decode is combinational from `in_inst`. Results are registered with `in_pc`/`in_inst` on accept.
- Opcode map:
  - LUI/AUIPC → U.
  - JAL → J.
  - JALR → I; illegal if funct3≠000.
  - BRANCH → B; illegal if funct3 is 010 or 011.
  - LOAD → I; legal funct3 only 000/001/010/100/101.
  - STORE → S; legal funct3 only 000/001/010.
  - OP-IMM → I; SLLI requires funct7=0; SRLI/SRAI require funct7 0000000/0100000.
  - OP → R; funct7 must be 0000000, or 0100000 only with funct3 000/101.
  - SYSTEM → I; legal are ecall 0x00000073, ebreak 0x00100073, and funct3 ∈ {001,010,011,101,110,111}.
  - Any other opcode, or `inst[1:0]`≠11 → illegal, fmt=I, imm=0.
- Immediates, all sign-extended from `inst[31]`:
  - I = `inst[31:20]`.
  - S = `{inst[31:25], inst[11:7]}`.
  - B = `{inst[31], inst[7], inst[30:25], inst[11:8], 0}`.
  - U = `{inst[31:12], 12'b0}`.
  - J = `{inst[31], inst[19:12], inst[20], inst[30:21], 0}`.
  - R = 0.
- `out_rd_we` = 0 for B, S, ecall, ebreak, illegal, or `rd`=0. Otherwise 1.
- `RVE`=1: illegal if `rs1[4]` (R/I/S/B), `rs2[4]` (R/S/B) or `rd[4]` (R/I/U/J) is set. Unused fields are not checked.

## Timing
- Reset: `out_valid`=0. `out_pc`, `out_inst`, `out_imm`, all indices, `out_fmt`, `out_rd_we` and `out_illegal` = 0.
- Latency: 1 cycle from accept to `out_valid`.
- Throughput: 1 instruction/cycle when `out_ready` is held high.
- Stall: while `out_valid && !out_ready`, all outputs are held bit-stable and `in_ready`=0.
- Transfer with no accept in the same cycle → `out_valid`=0 next cycle. Transfer and accept together → new entry next cycle, `out_valid` stays 1.
- `flush` (priority below `rst` only): next cycle `out_valid`=0, and no input is accepted in the flush cycle. Payload registers may keep stale values.
- `rst` mid-stall or mid-flush: reset values next cycle, regardless of the handshake.

## Test plan
- Reset with `in_valid`=1, `in_inst`=0x00000013 → during reset `in_ready`=1 but nothing is captured. Cycle after reset release: `out_valid`=0 and all outputs 0.
- Accept 0xFFF00093 (addi x1,x0,-1) at pc 0x80000000 → next cycle: `out_valid`=1, `out_imm`=0xFFFFFFFF, `out_fmt`=1, `out_rd`=1, `out_rd_we`=1, `out_illegal`=0.
- Immediates:
  - 0xFE000EE3 (beq, offset -4) → imm 0xFFFFFFFC, fmt=3, `out_rd_we`=0.
  - 0x008000EF (jal x1,+8) → imm 0x00000008, fmt=5.
  - 0x00112223 (sw x1,4(x2)) → imm 4, fmt=2.
- Back-pressure: hold `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0 and outputs stable throughout. On `out_ready`=1, transfer and accept happen in the same cycle.
- Flush while holding an entry with `in_valid`=1 → `in_ready`=0 that cycle, `out_valid`=0 next cycle, and the input is taken only in a later cycle.
- Illegal detection:
  - 0x00000000 → `out_illegal`=1, `out_rd_we`=0.
  - 0x40001033 (sll with funct7=0100000) → illegal.
  - With `RVE`=1, 0x01000813 (addi x16,x0,16) → illegal.
  - 0x00100073 (ebreak) → legal, `out_rd_we`=0.
